// File: rtl/dice_seg_display.sv
// dice_seg_display
// Display back-end for the dice roller. Shows a spinning-segment animation on
// two multiplexed common-cathode 7-segment digits while a roll is in progress,
// then latches the two-digit BCD result and shows it with leading-zero
// blanking. All outputs are registered and reflect the state, slot and
// counters of the previous cycle.

module dice_seg_display #(
  parameter int REFRESH_DIV = 16,  // clk cycles per digit slot, >= 2
  parameter int SPIN_DIV    = 2048 // clk cycles per animation step, >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bcd_in,
  input  logic       rolling,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       result_valid
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(SPIN_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] PRE_LAST = SW'(SPIN_DIV - 1);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_SPIN  = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Decode one BCD nibble to segments (bit 0 = a ... bit 6 = g); non-BCD shows "-".
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Single lit outer segment for an animation index 0..5 (a..f); g never lit.
  function automatic logic [6:0] spin_seg(input logic [2:0] idx);
    return 7'd1 << idx;
  endfunction

  // Tens digit runs half a revolution ahead: (phase + 3) mod 6.
  function automatic logic [2:0] tens_phase(input logic [2:0] p);
    return (p >= 3'd3) ? (p - 3'd3) : (p + 3'd3);
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    value_q, value_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          slot_q, slot_d;
  logic [SW-1:0] pre_q, pre_d;
  logic [2:0]    phase_q, phase_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_sel_q, dig_sel_d;
  logic          result_valid_q, result_valid_d;

  logic          spin_entry_s;
  logic          slot_on_s;
  logic          tens_blank_s;

  // Mode sequencing and result latch on the falling edge of the roll.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    case (state_q)
      ST_BLANK: begin
        if (rolling) begin
          state_d = ST_SPIN;
        end else begin
          state_d = ST_BLANK;
        end
      end
      ST_SPIN: begin
        if (!rolling) begin
          state_d = ST_SHOW;
          value_d = bcd_in;
        end else begin
          state_d = ST_SPIN;
        end
      end
      ST_SHOW: begin
        if (rolling) begin
          state_d = ST_SPIN;
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        state_d = ST_BLANK;
        value_d = 8'h00;
      end
    endcase
  end

  // Free-running refresh counter; the slot flips on its terminal count in every mode.
  always_comb begin
    ref_cnt_d = ref_cnt_q;
    slot_d    = slot_q;
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
      slot_d    = ~slot_q;
    end else begin
      ref_cnt_d = ref_cnt_q + RW'(1);
      slot_d    = slot_q;
    end
  end

  // Animation prescaler and phase; both restart whenever SPIN is entered.
  always_comb begin
    pre_d        = pre_q;
    phase_d      = phase_q;
    spin_entry_s = (state_d == ST_SPIN) && (state_q != ST_SPIN);
    if (spin_entry_s) begin
      pre_d   = '0;
      phase_d = 3'd0;
    end else if (state_q == ST_SPIN) begin
      if (pre_q == PRE_LAST) begin
        pre_d   = '0;
        phase_d = (phase_q == 3'd5) ? 3'd0 : (phase_q + 3'd1);
      end else begin
        pre_d   = pre_q + SW'(1);
        phase_d = phase_q;
      end
    end else begin
      pre_d   = pre_q;
      phase_d = phase_q;
    end
  end

  // Segment/digit drive for the current slot; digits stay dark on a slot's first cycle.
  always_comb begin
    seg_d          = 7'h00;
    dig_sel_d      = 2'b00;
    result_valid_d = 1'b0;
    slot_on_s      = (ref_cnt_q != '0);
    tens_blank_s   = (value_q[7:4] == 4'd0) && (value_q[3:0] != 4'd0);
    case (state_q)
      ST_BLANK: begin
        seg_d     = 7'h00;
        dig_sel_d = 2'b00;
      end
      ST_SPIN: begin
        if (slot_q) begin
          seg_d     = spin_seg(tens_phase(phase_q));
          dig_sel_d = slot_on_s ? 2'b10 : 2'b00;
        end else begin
          seg_d     = spin_seg(phase_q);
          dig_sel_d = slot_on_s ? 2'b01 : 2'b00;
        end
      end
      ST_SHOW: begin
        result_valid_d = 1'b1;
        if (!slot_q) begin
          seg_d     = seg_decode(value_q[3:0]);
          dig_sel_d = slot_on_s ? 2'b01 : 2'b00;
        end else if (tens_blank_s) begin
          seg_d     = 7'h00;
          dig_sel_d = 2'b00;
        end else begin
          seg_d     = seg_decode(value_q[7:4]);
          dig_sel_d = slot_on_s ? 2'b10 : 2'b00;
        end
      end
      default: begin
        seg_d          = 7'h00;
        dig_sel_d      = 2'b00;
        result_valid_d = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset returns to a dark BLANK display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_BLANK;
      value_q        <= 8'h00;
      ref_cnt_q      <= '0;
      slot_q         <= 1'b0;
      pre_q          <= '0;
      phase_q        <= 3'd0;
      seg_q          <= 7'h00;
      dig_sel_q      <= 2'b00;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      value_q        <= value_d;
      ref_cnt_q      <= ref_cnt_d;
      slot_q         <= slot_d;
      pre_q          <= pre_d;
      phase_q        <= phase_d;
      seg_q          <= seg_d;
      dig_sel_q      <= dig_sel_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign seg          = seg_q;
  assign dig_sel      = dig_sel_q;
  assign result_valid = result_valid_q;

endmodule
